// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared VGA timing constants, types and helpers
package vga_timing_pkg;

    localparam int CNT_W = 10;

    // Default 640x480@60 timing, in pixel ticks and lines
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    // Sync pulse bounds, inclusive
    localparam int H_SYNC_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
    localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF - 1;
    localparam int V_SYNC_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
    localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF - 1;

    // Logical (pixel-doubled) resolution seen by color_selector
    localparam int LOGIC_W = 320;
    localparam int LOGIC_H = 240;

    typedef logic [CNT_W-1:0] cnt_t;

    // Bits carried through the alignment delay line
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic video_on;
    } sync_bits_t;

    localparam sync_bits_t SYNC_IDLE = '{hsync: 1'b1, vsync: 1'b1, video_on: 1'b0};

    function automatic logic in_window(cnt_t c, cnt_t lo, cnt_t hi);
        return (c >= lo) && (c <= hi);
    endfunction

endpackage

// File: rtl/vga_scan_gen_if.sv
// rtl/vga_scan_gen_if.sv - coordinate/colour loop and connector signals of the scan generator
interface vga_scan_gen_if;
    logic [2:0] color;
    logic [8:0] xvga;
    logic [7:0] yvga;
    logic       pix_tick;
    logic       frame_start;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       vga_r;
    logic       vga_g;
    logic       vga_b;

    modport master (
        input  color,
        output xvga, yvga, pix_tick, frame_start,
        output hsync, vsync, video_on, vga_r, vga_g, vga_b
    );

    modport slave (
        output color,
        input  xvga, yvga, pix_tick, frame_start,
        input  hsync, vsync, video_on, vga_r, vga_g, vga_b
    );
endinterface

// File: rtl/sync_delay.sv
// rtl/sync_delay.sv - tick-enabled shift register with reset value and look-ahead output
module sync_delay #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic [WIDTH-1:0] next_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    // Shift one stage per enable; reset loads the idle value into every stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
        end else if (en_i) begin
            stage_q[0] <= din_i;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign dout_o = stage_q[DEPTH-1];

    // next_o is what dout_o becomes after this edge, so downstream registers can stay aligned
    generate
        if (DEPTH == 1) begin : g_single
            assign next_o = en_i ? din_i : stage_q[0];
        end else begin : g_multi
            assign next_o = en_i ? stage_q[DEPTH-2] : stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_scan_gen.sv
// rtl/vga_scan_gen.sv - VGA raster scan generator and blanked RGB stage (option: VGA_SCAN_ALIGN_EN)
module vga_scan_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV    = 2,
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int H_FP       = H_FP_DEF,
    parameter int H_SYNC     = H_SYNC_DEF,
    parameter int H_BP       = H_BP_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int V_FP       = V_FP_DEF,
    parameter int V_SYNC     = V_SYNC_DEF,
    parameter int V_BP       = V_BP_DEF,
    parameter int PIPE_DELAY = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    vga_scan_gen_if.master vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam cnt_t H_LAST   = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_LAST   = cnt_t'(V_TOTAL - 1);
    localparam cnt_t H_ACT    = cnt_t'(H_ACTIVE);
    localparam cnt_t V_ACT    = cnt_t'(V_ACTIVE);
    localparam cnt_t HS_START = cnt_t'(H_ACTIVE + H_FP);
    localparam cnt_t HS_END   = cnt_t'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam cnt_t VS_START = cnt_t'(V_ACTIVE + V_FP);
    localparam cnt_t VS_END   = cnt_t'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    cnt_t             hcount_q, hcount_d;
    cnt_t             vcount_q, vcount_d;
    logic             tick, h_wrap, v_wrap;

    logic             active_d, hsync_raw_d, vsync_raw_d, frame_start_d;
    logic [8:0]       xvga_d;
    logic [7:0]       yvga_d;
    logic             active_q, hsync_raw_q, vsync_raw_q, frame_start_q, pix_tick_q;
    logic [8:0]       xvga_q;
    logic [7:0]       yvga_q;
    logic [2:0]       rgb_q, rgb_d;

    logic             vid_next;
    logic             hsync_out, vsync_out, video_on_out;

    assign tick   = (div_cnt_q == DIV_LAST);
    assign h_wrap = (hcount_q == H_LAST);
    assign v_wrap = (vcount_q == V_LAST);

    // Divider and raster counters; counters move only on the pixel tick
    always_comb begin
        div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
        hcount_d  = hcount_q;
        vcount_d  = vcount_q;
        if (tick) begin
            if (h_wrap) begin
                hcount_d = '0;
                vcount_d = v_wrap ? '0 : vcount_q + 1'b1;
            end else begin
                hcount_d = hcount_q + 1'b1;
            end
        end
    end

    // Decode of the current counter state into the raw output values
    always_comb begin
        active_d      = (hcount_q < H_ACT) && (vcount_q < V_ACT);
        hsync_raw_d   = !in_window(hcount_q, HS_START, HS_END);
        vsync_raw_d   = !in_window(vcount_q, VS_START, VS_END);
        xvga_d        = active_d ? hcount_q[9:1] : '0;
        yvga_d        = active_d ? vcount_q[8:1] : '0;
        frame_start_d = tick && h_wrap && v_wrap;
    end

    // Counter state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            hcount_q  <= '0;
            vcount_q  <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            hcount_q  <= hcount_d;
            vcount_q  <= vcount_d;
        end
    end

    // Registered raw outputs; pix_tick/frame_start land on the edge that moves the counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_tick_q    <= 1'b0;
            frame_start_q <= 1'b0;
            xvga_q        <= '0;
            yvga_q        <= '0;
            active_q      <= 1'b0;
            hsync_raw_q   <= 1'b1;
            vsync_raw_q   <= 1'b1;
        end else begin
            pix_tick_q    <= tick;
            frame_start_q <= frame_start_d;
            xvga_q        <= xvga_d;
            yvga_q        <= yvga_d;
            active_q      <= active_d;
            hsync_raw_q   <= hsync_raw_d;
            vsync_raw_q   <= vsync_raw_d;
        end
    end

`ifdef VGA_SCAN_ALIGN_EN
    sync_bits_t raw_bits, dly_bits, dly_next;

    assign raw_bits = {hsync_raw_q, vsync_raw_q, active_q};

    // Advancing on pix_tick_q samples the raw registers just before they update, so each stage is one pixel tick
    sync_delay #(
        .WIDTH   (3),
        .DEPTH   (PIPE_DELAY),
        .RST_VAL (SYNC_IDLE)
    ) u_sync_delay (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (pix_tick_q),
        .din_i  (raw_bits),
        .dout_o (dly_bits),
        .next_o (dly_next)
    );

    assign vid_next     = dly_next.video_on;
    assign hsync_out    = dly_bits.hsync;
    assign vsync_out    = dly_bits.vsync;
    assign video_on_out = dly_bits.video_on;
`else
    assign vid_next     = active_d;
    assign hsync_out    = hsync_raw_q;
    assign vsync_out    = vsync_raw_q;
    assign video_on_out = active_q;
`endif

    assign rgb_d = vga.color & {3{vid_next}};

    // RGB is gated with the video_on value that becomes visible on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign vga.xvga        = xvga_q;
    assign vga.yvga        = yvga_q;
    assign vga.pix_tick    = pix_tick_q;
    assign vga.frame_start = frame_start_q;
    assign vga.hsync       = hsync_out;
    assign vga.vsync       = vsync_out;
    assign vga.video_on    = video_on_out;
    assign vga.vga_r       = rgb_q[2];
    assign vga.vga_g       = rgb_q[1];
    assign vga.vga_b       = rgb_q[0];

endmodule

// File: tb/tb_vga_scan_gen.sv
// tb/tb_vga_scan_gen.sv - directed self-checking bench for vga_scan_gen on a reduced raster
module tb_vga_scan_gen;

    localparam int D  = 2;
    localparam int HA = 16, HF = 2, HS = 4, HB = 3;
    localparam int VA = 8,  VF = 1, VS = 2, VB = 2;
    localparam int HT    = HA + HF + HS + HB;
    localparam int VT    = VA + VF + VS + VB;
    localparam int LINE  = D * HT;
    localparam int FRAME = LINE * VT;
`ifdef VGA_SCAN_ALIGN_EN
    localparam int LAG = D;
`else
    localparam int LAG = 0;
`endif

    localparam logic [24:0] RST_VEC = {9'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'b000};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    vga_scan_gen_if vif ();

    vga_scan_gen #(
        .CLK_DIV (D),
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .PIPE_DELAY(1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .vga  (vif)
    );

    always #5 clk = ~clk;

    function automatic logic [24:0] out_vec();
        return {vif.xvga, vif.yvga, vif.pix_tick, vif.frame_start, vif.hsync,
                vif.vsync, vif.video_on, vif.vga_r, vif.vga_g, vif.vga_b};
    endfunction

    function automatic logic [2:0] rgb();
        return {vif.vga_r, vif.vga_g, vif.vga_b};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int bad = 0;
        vif.color = 3'b111;
        rst_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_vec() !== RST_VEC) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL reset_hold bad_cycles %0d want 0", bad); end
        checks++;
        if (out_vec() !== RST_VEC) begin errors++; $display("FAIL reset_vec got %h want %h", out_vec(), RST_VEC); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (vif.pix_tick !== 1'b0) begin errors++; $display("FAIL tick_c1 got %b want 0", vif.pix_tick); end
        checks++;
        if (vif.xvga !== 9'd0 || vif.yvga !== 8'd0) begin
            errors++; $display("FAIL coord_c1 got %0d,%0d want 0,0", vif.xvga, vif.yvga);
        end
        checks++;
        if (vif.video_on !== (LAG == 0)) begin errors++; $display("FAIL video_on_c1 got %b want %b", vif.video_on, LAG == 0); end
        @(negedge clk);
        checks++;
        if (vif.pix_tick !== 1'b1) begin errors++; $display("FAIL tick_c2 got %b want 1", vif.pix_tick); end
        @(negedge clk);
        checks++;
        if (vif.pix_tick !== 1'b0) begin errors++; $display("FAIL tick_c3 got %b want 0", vif.pix_tick); end
    endtask

    task automatic test_hsync();
        int first_fall = -1, low_cnt = 0, xmax = 0;
        logic [8:0] x_last = '1, x_after = '1;
        logic vo_in = 1'b0, vo_out = 1'b1;
        vif.color = 3'b000;
        do_reset();
        for (int c = 1; c <= LINE; c++) begin
            @(negedge clk);
            if (vif.hsync === 1'b0) begin
                if (first_fall < 0) first_fall = c;
                low_cnt++;
            end
            if (int'(vif.xvga) > xmax) xmax = int'(vif.xvga);
            if (c == 2 * HA)           x_last  = vif.xvga;
            if (c == 2 * HA + 1)       x_after = vif.xvga;
            if (c == 2 * HA + LAG)     vo_in   = vif.video_on;
            if (c == 2 * HA + 1 + LAG) vo_out  = vif.video_on;
        end
        checks++;
        if (first_fall != (HA + HF) * D + 1 + LAG) begin
            errors++; $display("FAIL hsync_fall got %0d want %0d", first_fall, (HA + HF) * D + 1 + LAG);
        end
        checks++;
        if (low_cnt != HS * D) begin errors++; $display("FAIL hsync_width got %0d want %0d", low_cnt, HS * D); end
        checks++;
        if (xmax != HA / 2 - 1) begin errors++; $display("FAIL xvga_max got %0d want %0d", xmax, HA / 2 - 1); end
        checks++;
        if (x_last !== 9'(HA / 2 - 1)) begin errors++; $display("FAIL xvga_last got %0d want %0d", x_last, HA / 2 - 1); end
        checks++;
        if (x_after !== 9'd0) begin errors++; $display("FAIL xvga_blank got %0d want 0", x_after); end
        checks++;
        if (vo_in !== 1'b1 || vo_out !== 1'b0) begin
            errors++; $display("FAIL video_on_edge got %b%b want 10", vo_in, vo_out);
        end
    endtask

    task automatic test_frame();
        int first_vs = -1, vs_cnt = 0, ymax = 0, fs_cnt = 0, fs_first = -1, fs_second = -1, fs_no_tick = 0;
        vif.color = 3'b000;
        do_reset();
        for (int c = 1; c <= 2 * FRAME + 5; c++) begin
            @(negedge clk);
            if (c <= FRAME && vif.vsync === 1'b0) begin
                if (first_vs < 0) first_vs = c;
                vs_cnt++;
            end
            if (int'(vif.yvga) > ymax) ymax = int'(vif.yvga);
            if (vif.frame_start === 1'b1) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = c;
                else if (fs_second < 0) fs_second = c;
                if (vif.pix_tick !== 1'b1) fs_no_tick++;
            end
        end
        checks++;
        if (first_vs != (VA + VF) * LINE + 1 + LAG) begin
            errors++; $display("FAIL vsync_start got %0d want %0d", first_vs, (VA + VF) * LINE + 1 + LAG);
        end
        checks++;
        if (vs_cnt != VS * LINE) begin errors++; $display("FAIL vsync_width got %0d want %0d", vs_cnt, VS * LINE); end
        checks++;
        if (ymax != VA / 2 - 1) begin errors++; $display("FAIL yvga_max got %0d want %0d", ymax, VA / 2 - 1); end
        checks++;
        if (fs_cnt != 2 || fs_first != FRAME || fs_second != 2 * FRAME) begin
            errors++; $display("FAIL frame_start got n=%0d at %0d,%0d want n=2 at %0d,%0d",
                               fs_cnt, fs_first, fs_second, FRAME, 2 * FRAME);
        end
        checks++;
        if (fs_no_tick != 0) begin errors++; $display("FAIL frame_start_tick got %0d want 0", fs_no_tick); end
    endtask

    task automatic test_blanking();
        int bad = 0, on_cnt = 0;
        do_reset();
        vif.color = 3'b111;
        for (int c = 1; c <= FRAME; c++) begin
            @(negedge clk);
            if (rgb() !== (vif.video_on ? 3'b111 : 3'b000)) bad++;
            if (rgb() === 3'b111) on_cnt++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL blank_white got %0d want 0", bad); end
        checks++;
        if (on_cnt != HA * VA * D) begin errors++; $display("FAIL white_count got %0d want %0d", on_cnt, HA * VA * D); end
        vif.color = 3'b010;
        bad = 0;
        on_cnt = 0;
        for (int c = 1; c <= FRAME; c++) begin
            @(negedge clk);
            if (rgb() !== (vif.video_on ? 3'b010 : 3'b000)) bad++;
            if (rgb() === 3'b010) on_cnt++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL blank_green got %0d want 0", bad); end
        checks++;
        if (on_cnt != HA * VA * D) begin errors++; $display("FAIL green_count got %0d want %0d", on_cnt, HA * VA * D); end
    endtask

    task automatic test_mid_reset();
        int fs_first = -1;
        logic [8:0] x1 = '1;
        do_reset();
        vif.color = 3'b111;
        for (int c = 1; c <= 3 * LINE + 2 * 10 + 1; c++) @(negedge clk);
        checks++;
        if (vif.xvga !== 9'd5 || vif.yvga !== 8'd1 || vif.video_on !== 1'b1 || rgb() !== 3'b111) begin
            errors++; $display("FAIL pre_reset got x=%0d y=%0d vo=%b rgb=%b want 5 1 1 111",
                               vif.xvga, vif.yvga, vif.video_on, rgb());
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_vec() !== RST_VEC) begin errors++; $display("FAIL mid_reset got %h want %h", out_vec(), RST_VEC); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= FRAME + 10; c++) begin
            @(negedge clk);
            if (c == 1) x1 = vif.xvga;
            if (vif.frame_start === 1'b1 && fs_first < 0) fs_first = c;
        end
        checks++;
        if (x1 !== 9'd0) begin errors++; $display("FAIL restart_x got %0d want 0", x1); end
        checks++;
        if (fs_first != FRAME) begin errors++; $display("FAIL restart_frame got %0d want %0d", fs_first, FRAME); end
    endtask

    initial begin
        vif.color = 3'b000;
        test_reset();
        test_hsync();
        test_frame();
        test_blanking();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_scan_gen.md
# vga_scan_gen

Raster scan generator and pixel output stage for the Simon VGA display. It produces the 640x480@60 Hz sync timing and the pixel-doubled 320x240 coordinates (`xvga`, `yvga`) consumed by `color_selector`. It takes back the 3-bit `color` that `color_selector` returns and drives the blanked RGB lines to the connector. It closes the coordinate-out / colour-in loop around `color_selector`.

## Interface
Parameters:
- `CLK_DIV`, default 2: system clocks per pixel tick (50 MHz to 25 MHz); must be at least 1.
- `H_ACTIVE`, `H_FP`, `H_SYNC`, `H_BP`, defaults 640, 16, 96, 48: horizontal timing in pixel ticks.
- `V_ACTIVE`, `V_FP`, `V_SYNC`, `V_BP`, defaults 480, 10, 2, 33: vertical timing in lines.
- `PIPE_DELAY`, default 1: pixel ticks of latency in `color_selector`; used only with `VGA_SCAN_ALIGN_EN`.

Ports:
- `clk`  in  1: system clock. One clock domain only.
- `rst_n`  in  1: reset, asynchronous assert, active-low.
- `color`  in  3: {r,g,b} from `color_selector` for the coordinates issued earlier.
- `xvga`  out  9: `hcount[9:1]` while in active area, else 0.
- `yvga`  out  8: `vcount[8:1]` while in active area, else 0.
- `pix_tick`  out  1: one-`clk` pulse every `CLK_DIV` clocks.
- `frame_start`  out  1: one-`clk` pulse on the tick where the counters wrap to (0,0).
- `hsync`  out  1: horizontal sync, active-low.
- `vsync`  out  1: vertical sync, active-low.
- `video_on`  out  1: high in the active area (aligned to RGB).
- `vga_r`, `vga_g`, `vga_b`  out  1 each: pixel output, forced to 0 when `video_on` is 0.

## Operation
- **Divider.** `div_cnt` counts 0..`CLK_DIV`-1. `pix_tick` is high when `div_cnt` = `CLK_DIV`-1. With `CLK_DIV` = 1, `pix_tick` is constantly high.
- **Horizontal counter.** On each tick, `hcount` counts 0..H_TOTAL-1 (800) and wraps to 0.
- **Vertical counter.** On each tick where `hcount` wraps, `vcount` counts 0..V_TOTAL-1 (525) and wraps to 0.
- **Active area.** Defined as `hcount` < `H_ACTIVE` and `vcount` < `V_ACTIVE`.
- **Sync windows.**
  - `hsync` is low for `hcount` in [`H_ACTIVE`+`H_FP`, `H_ACTIVE`+`H_FP`+`H_SYNC`-1], i.e. [656, 751].
  - `vsync` is low for `vcount` in [490, 491].
- **Registered outputs.** `xvga`, `yvga`, raw active, raw `hsync` and raw `vsync` are registered from the counter state. They update on the `clk` edge after the tick that moves the counters.
- **RGB.** `vga_r/g/b` are registered: `color` bits ANDed with the aligned `video_on`.
- **Counter width.** Counters are 10 bits; no saturation. Parameter values giving H_TOTAL or V_TOTAL above 1024 are unsupported.
- **Reset values.**
  - Internal: `div_cnt`, `hcount`, `vcount` = 0.
  - Outputs: `xvga` = 0, `yvga` = 0, `pix_tick` = 0, `frame_start` = 0, `hsync` = 1, `vsync` = 1, `video_on` = 0, RGB = 0.
  - Delay-line contents reset to the inactive state (sync high, `video_on` low).
- **Reset mid-frame.** All outputs return immediately to their reset values. Scanning restarts at (0,0). The first `frame_start` after release comes at the first wrap, one full frame later.

## Timing
- Line = `CLK_DIV`·800 clocks (1600 at the defaults).
- Frame = `CLK_DIV`·800·525 clocks (840000 at the defaults).
- Coordinate latency: `xvga`/`yvga` lag the counters by 1 `clk`.
- `color` is sampled on every `clk` edge. The value used is whatever `color_selector` presents, so alignment is expressed in pixel ticks.
- `frame_start` and `pix_tick` are coincident on the wrap tick. `frame_start` is never asserted without `pix_tick`.

## Configuration
- **`VGA_SCAN_ALIGN_EN` defined:** `hsync`, `vsync` and `video_on` pass through a `PIPE_DELAY`-stage delay line that advances only on `pix_tick`. This matches the registered latency of `color_selector`, so RGB, sync and blanking line up at the connector.
- **`VGA_SCAN_ALIGN_EN` undefined:** the delay line is absent. Sync and `video_on` come straight from the raw registers, and `PIPE_DELAY` is ignored.

## Structure
- **Shared package `vga_timing_pkg`:**
  - Default timing constants.
  - Derived `H_TOTAL` / `V_TOTAL`.
  - Sync-window bounds.
  - 320x240 logical-resolution constants, which `color_selector` also uses.
- **Sub-module `sync_delay`:** a parameterised-depth shift register with tick enable and asynchronous active-low reset value. It is instantiated 3 bits wide when `VGA_SCAN_ALIGN_EN` is defined.

## Test plan
- **Reset release:** hold `rst_n` low 10 clocks, then release → all outputs at reset values during reset; first `pix_tick` 2 clocks after release; `xvga` = 0, `yvga` = 0, `video_on` = 1 (macro off).
- **Horizontal sync:** run 1 line → `hsync` falls exactly 1312 clocks after line start, low for 192 clocks; `xvga` reaches 319, then reads 0 from `hcount` = 640.
- **Vertical and frame:** run 1 frame → `vsync` low for exactly 2 lines starting at line 490; `yvga` max 239; `frame_start` pulses once per 840000 clocks.
- **Blanking:** `color` = 3'b111 constant → RGB = 111 only while `video_on` = 1; RGB = 0 in all blanking.
- **Alignment (macro on, `PIPE_DELAY` = 1):** `video_on` and `hsync` edges lag the macro-off edges by exactly one pixel tick (2 clocks).
- **Reset mid-frame:** pulse `rst_n` low at line 300, `hcount` 400 → immediate reset values; counters restart at 0; next `frame_start` 840000 clocks after release.
